// File: rtl/lut_sweeper_if.sv
// Handshake bundle for lut_sweeper: table load, sweep control and the per-index sample stream.
// master drives the controls (bench or host); slave is the sweeper itself.
interface lut_sweeper_if #(
   parameter int unsigned N_IN = 3
);
   localparam int unsigned TT_W = 2 ** N_IN;

   logic            load;
   logic [TT_W-1:0] tt_in;
   logic            start;
   logic            inv;
   logic            hold;
   logic            busy;
   logic            valid;
   logic [N_IN-1:0] idx_out;
   logic            f_out;
   logic [N_IN:0]   ones_cnt;
   logic            done;

   modport master (
      output load, tt_in, start, inv, hold,
      input  busy, valid, idx_out, f_out, ones_cnt, done
   );

   modport slave (
      input  load, tt_in, start, inv, hold,
      output busy, valid, idx_out, f_out, ones_cnt, done
   );
endinterface

// File: rtl/lut_sweeper.sv
// Programmable N_IN-input truth table that, on start, walks every input combination in order,
// emitting f per index with a valid strobe, counting minterms and pulsing done at the end.
module lut_sweeper #(
   parameter int unsigned N_IN = 3
) (
   input logic         clk,
   input logic         rst,
   lut_sweeper_if.slave bus
);
   localparam int unsigned TT_W = 2 ** N_IN;
   localparam logic [N_IN-1:0] IDX_LAST = N_IN'(TT_W - 1);

   typedef enum logic [1:0] {StIdle, StSweep, StDone} state_e;

   state_e          state;
   logic [TT_W-1:0] tt_reg;
   logic            inv_reg;
   logic [N_IN-1:0] idx;
   logic            valid;
   logic [N_IN-1:0] idx_out;
   logic            f_out;
   logic [N_IN:0]   ones_cnt;
   logic            done;
   logic            f_bit;

   assign f_bit = tt_reg[idx] ^ inv_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= StIdle;
         tt_reg   <= '0;
         inv_reg  <= 1'b0;
         idx      <= '0;
         valid    <= 1'b0;
         idx_out  <= '0;
         f_out    <= 1'b0;
         ones_cnt <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            StIdle: begin
               // load and start together both apply, so the sweep sees the new table
               if (bus.load) tt_reg <= bus.tt_in;
               if (bus.start) begin
                  inv_reg  <= bus.inv;
                  idx      <= '0;
                  ones_cnt <= '0;
                  state    <= StSweep;
               end
            end
            StSweep: begin
               if (bus.hold) begin
                  valid <= 1'b0;
               end else begin
                  valid    <= 1'b1;
                  idx_out  <= idx;
                  f_out    <= f_bit;
                  ones_cnt <= ones_cnt + (N_IN + 1)'(f_bit);
                  idx      <= idx + N_IN'(1);
                  if (idx == IDX_LAST) state <= StDone;
               end
            end
            StDone: begin
               valid <= 1'b0;
               done  <= 1'b1;
               state <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

   assign bus.busy     = (state != StIdle);
   assign bus.valid    = valid;
   assign bus.idx_out  = idx_out;
   assign bus.f_out    = f_out;
   assign bus.ones_cnt = ones_cnt;
   assign bus.done     = done;
endmodule

// File: tb/tb_lut_sweeper.sv
// Directed bench for lut_sweeper: one N_IN=3 and one N_IN=4 instance sharing clock and reset.
module tb_lut_sweeper;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   lut_sweeper_if #(.N_IN(3)) if3 ();
   lut_sweeper_if #(.N_IN(4)) if4 ();

   lut_sweeper #(.N_IN(3)) u3 (.clk(clk), .rst(rst), .bus(if3.slave));
   lut_sweeper #(.N_IN(4)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));

   int   n_err = 0;
   int   n_checks = 0;
   bit   sel4 = 1'b0;

   logic       s_busy, s_valid, s_f, s_done;
   logic [3:0] s_idx;
   logic [4:0] s_ones;

   always_comb begin
      s_busy  = sel4 ? if4.busy  : if3.busy;
      s_valid = sel4 ? if4.valid : if3.valid;
      s_f     = sel4 ? if4.f_out : if3.f_out;
      s_done  = sel4 ? if4.done  : if3.done;
      s_idx   = sel4 ? if4.idx_out : {1'b0, if3.idx_out};
      s_ones  = sel4 ? if4.ones_cnt : {1'b0, if3.ones_cnt};
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic ld, input logic [15:0] tt, input logic st, input logic iv,
                        input logic hd);
      if (sel4) begin
         if4.load = ld; if4.tt_in = tt; if4.start = st; if4.inv = iv; if4.hold = hd;
      end else begin
         if3.load = ld; if3.tt_in = tt[7:0]; if3.start = st; if3.inv = iv; if3.hold = hd;
      end
   endtask

   // Caller drives start (cycle t) before calling. hmask bit k = hold high during cycle t+k;
   // at cycle t+poke a load of 0 plus start/inv is attempted while busy.
   task automatic sweep(input logic [15:0] exp_f, input int tt_w, input logic [63:0] hmask,
                        input int exp_done, input int exp_ones, input int poke,
                        input string tag);
      int   nxt   = 0;
      int   phase = 0;
      logic hd;
      tick();
      check({tag, " busy_t1"}, s_busy, 1);
      check({tag, " ones_clr"}, s_ones, 0);
      for (int k = 1; k < 40 && phase != 2; k++) begin
         hd = hmask[k];
         if (k == poke) drive(1'b1, 16'h0, 1'b1, 1'b1, hd);
         else           drive(1'b0, 16'h0, 1'b0, 1'b0, hd);
         tick();
         if (phase == 1) begin
            phase = 2;
            check({tag, " done_cycle"}, k + 1, exp_done);
            check({tag, " done"}, s_done, 1);
            check({tag, " valid_at_done"}, s_valid, 0);
            check({tag, " busy_at_done"}, s_busy, 0);
            check({tag, " ones"}, s_ones, exp_ones);
         end else begin
            check({tag, " done_low"}, s_done, 0);
            if (!hd) begin
               check({tag, " valid"}, s_valid, 1);
               check({tag, " idx"}, s_idx, nxt);
               check({tag, " f"}, s_f, exp_f[nxt]);
               nxt++;
               if (nxt == tt_w) phase = 1;
            end else begin
               check({tag, " valid_hold"}, s_valid, 0);
               if (nxt > 0) check({tag, " idx_hold"}, s_idx, nxt - 1);
            end
         end
      end
      if (phase != 2) check({tag, " timeout"}, phase, 2);
      drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      tick();
      check({tag, " done_pulse_end"}, s_done, 0);
      check({tag, " ones_kept"}, s_ones, exp_ones);
   endtask

   initial begin
      sel4 = 1'b1; drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      sel4 = 1'b0; drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      tick(); tick();
      rst = 1'b0;
      tick();
      check("rst busy", s_busy, 0);
      check("rst valid", s_valid, 0);
      check("rst idx", s_idx, 0);
      check("rst f", s_f, 0);
      check("rst ones", s_ones, 0);
      check("rst done", s_done, 0);

      drive(1'b1, 16'h00FF, 1'b1, 1'b0, 1'b0);
      sweep(16'h00FF, 8, 64'h0, 10, 8, -1, "all_ones");

      drive(1'b1, 16'h0096, 1'b1, 1'b0, 1'b0);
      sweep(16'h0096, 8, 64'h0, 10, 4, -1, "parity");
      drive(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
      sweep(16'h0069, 8, 64'h0, 10, 4, -1, "parity_inv");
      drive(1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
      sweep(16'h00FF, 8, 64'h0, 10, 8, -1, "zero_inv");

      drive(1'b1, 16'h0096, 1'b1, 1'b0, 1'b0);
      sweep(16'h0096, 8, 64'h30, 12, 4, -1, "hold2");

      drive(1'b1, 16'h00FF, 1'b1, 1'b0, 1'b0);
      sweep(16'h00FF, 8, 64'h0, 10, 8, 3, "busy_ignore");
      drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      sweep(16'h00FF, 8, 64'h0, 10, 8, -1, "table_kept");

      // reset in the cycle idx 4 is presented
      drive(1'b1, 16'h00FF, 1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) tick();
      check("pre_rst idx", s_idx, 4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst busy", s_busy, 0);
      check("mid_rst valid", s_valid, 0);
      check("mid_rst ones", s_ones, 0);
      check("mid_rst done", s_done, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("mid_rst no_done", s_done, 0);
      end
      drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      sweep(16'h0000, 8, 64'h0, 10, 0, -1, "after_rst");

      sel4 = 1'b1;
      drive(1'b1, 16'h8000, 1'b1, 1'b0, 1'b0);
      sweep(16'h8000, 16, 64'h0, 18, 1, -1, "n4_msb");
      drive(1'b1, 16'h0001, 1'b1, 1'b0, 1'b0);
      sweep(16'h0001, 16, 64'h0, 18, 1, -1, "n4_lsb");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
